// File: rtl/branch_target_unit.sv
// Branch/jump target generator with a 2-entry valid/ready output buffer (HEAD + SKID).
// Optional target misalignment flag: define BTU_MISALIGN_CHECK_EN to build it.
module branch_target_unit #(
  parameter int XLEN       = 32,
  parameter int IMM_SHIFT  = 0,
  parameter int ALIGN_BITS = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_mode,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic [1:0]      out_mode,
  output logic            out_misaligned
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BRANCH = 2'b00;
  localparam logic [1:0] MODE_JAL    = 2'b01;
  localparam logic [1:0] MODE_JALR   = 2'b10;

  // Out-of-range configurations leave a marker scope in the elaborated hierarchy.
  if (ALIGN_BITS < 1 || ALIGN_BITS >= XLEN || IMM_SHIFT < 0 || IMM_SHIFT > 3) begin : g_bad_config
  end

  state_t          state_reg;
  logic [XLEN-1:0] head_target_reg;
  logic [XLEN-1:0] head_link_reg;
  logic [1:0]      head_mode_reg;
  logic            head_mis_reg;
  logic [XLEN-1:0] skid_target_reg;
  logic [XLEN-1:0] skid_link_reg;
  logic [1:0]      skid_mode_reg;
  logic            skid_mis_reg;

  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_next;
  logic [XLEN-1:0] link_next;
  logic            mis_next;
  logic            push;
  logic            pop;

  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    imm_s     = in_imm << IMM_SHIFT;
    jalr_sum  = in_rs1 + imm_s;
    link_next = in_pc + XLEN'(4);
    case (in_mode)
      MODE_BRANCH, MODE_JAL: target_next = in_pc + imm_s;
      MODE_JALR:             target_next = {jalr_sum[XLEN-1:1], 1'b0};
      default:               target_next = link_next;
    endcase
`ifdef BTU_MISALIGN_CHECK_EN
    mis_next = |target_next[ALIGN_BITS-1:0];
`else
    mis_next = 1'b0;
`endif
  end

  // HEAD always holds the oldest result; SKID only fills while HEAD is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= EMPTY;
      head_target_reg <= '0;
      head_link_reg   <= '0;
      head_mode_reg   <= '0;
      head_mis_reg    <= 1'b0;
      skid_target_reg <= '0;
      skid_link_reg   <= '0;
      skid_mode_reg   <= '0;
      skid_mis_reg    <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_target_reg <= target_next;
            head_link_reg   <= link_next;
            head_mode_reg   <= in_mode;
            head_mis_reg    <= mis_next;
            state_reg       <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_target_reg <= target_next;
            head_link_reg   <= link_next;
            head_mode_reg   <= in_mode;
            head_mis_reg    <= mis_next;
          end else if (push) begin
            skid_target_reg <= target_next;
            skid_link_reg   <= link_next;
            skid_mode_reg   <= in_mode;
            skid_mis_reg    <= mis_next;
            state_reg       <= TWO;
          end else if (pop) begin
            state_reg <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_target_reg <= skid_target_reg;
            head_link_reg   <= skid_link_reg;
            head_mode_reg   <= skid_mode_reg;
            head_mis_reg    <= skid_mis_reg;
            state_reg       <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

  assign out_target     = head_target_reg;
  assign out_link       = head_link_reg;
  assign out_mode       = head_mode_reg;
  assign out_misaligned = head_mis_reg;

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: directed plan cases plus randomized traffic.
module tb_branch_target_unit;
  localparam int XLEN       = 32;
  localparam int IMM_SHIFT  = 0;
  localparam int ALIGN_BITS = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = 2'd0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_target;
  logic [31:0] out_link;
  logic [1:0]  out_mode;
  logic        out_misaligned;

  typedef struct packed {
    logic [31:0] target;
    logic [31:0] link;
    logic [1:0]  mode;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  branch_target_unit #(.XLEN(XLEN), .IMM_SHIFT(IMM_SHIFT), .ALIGN_BITS(ALIGN_BITS)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_target(out_target), .out_link(out_link), .out_mode(out_mode),
    .out_misaligned(out_misaligned)
  );

  always #5 clock = ~clock;

  // Reference behaviour straight from the mode rules.
  function automatic exp_t model(input logic [1:0] mode, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] imm);
    exp_t e;
    logic [31:0] imm_s;
    imm_s  = imm << IMM_SHIFT;
    e.link = pc + 32'd4;
    case (mode)
      2'd0, 2'd1: e.target = pc + imm_s;
      2'd2:       e.target = (rs1 + imm_s) & ~32'd1;
      default:    e.target = pc + 32'd4;
    endcase
    e.mode = mode;
`ifdef BTU_MISALIGN_CHECK_EN
    e.mis = (e.target % (32'd1 << ALIGN_BITS)) != 0;
`else
    e.mis = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Expectation recorder: a push happens at the edge following this sample.
  always @(negedge clock) begin
    if (!reset && in_valid && in_ready)
      exp_q.push_back(model(in_mode, in_pc, in_rs1, in_imm));
  end

  // Monitor: compare every popped head against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got target 0x%08h, required no output", out_target);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_target", out_target, mon_e.target);
        check("out_link", out_link, mon_e.link);
        check("out_mode", 32'(out_mode), 32'(mon_e.mode));
        check("out_misaligned", 32'(out_misaligned), 32'(mon_e.mis));
        $display("[TB] result mode=%0d target=0x%08h link=0x%08h mis=%0b",
                 out_mode, out_target, out_link, out_misaligned);
      end
    end
  end

  task automatic set_in(input logic [1:0] mode, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] imm);
    in_mode = mode;
    in_pc   = pc;
    in_rs1  = rs1;
    in_imm  = imm;
  endtask

  task automatic send(input logic [1:0] mode, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] imm);
    int n;
    n = 0;
    @(posedge clock); #1;
    set_in(mode, pc, rs1, imm);
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("accept_in_time", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_target"}, out_target, 32'd0);
    check({tag, "_out_link"}, out_link, 32'd0);
    check({tag, "_out_mode"}, 32'(out_mode), 32'd0);
    check({tag, "_out_mis"}, 32'(out_misaligned), 32'd0);
  endtask

  task automatic directed(input string name, input logic [1:0] mode, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] t, input logic [31:0] l, input logic m);
    drain();
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(mode, pc, rs1, imm);
    check({name, "_latency_valid"}, 32'(out_valid), 32'd1);
    check({name, "_target"}, out_target, t);
    check({name, "_link"}, out_link, l);
    check({name, "_mis"}, 32'(out_misaligned), 32'(m));
    out_ready = 1'b1;
  endtask

  logic exp_mis_on;

  initial begin
`ifdef BTU_MISALIGN_CHECK_EN
    exp_mis_on = 1'b1;
`else
    exp_mis_on = 1'b0;
`endif
    reset = 1'b1;
    #12;
    check_reset_outputs("init_reset");
    @(posedge clock); #3;
    reset = 1'b0;

    directed("branch", 2'd0, 32'h0000_1000, 32'h0, 32'hFFFF_FFF8, 32'h0000_0FF8, 32'h0000_1004, 1'b0);
    directed("jalr", 2'd2, 32'h0000_0040, 32'h0000_2003, 32'h0000_0004, 32'h0000_2006, 32'h0000_0044, exp_mis_on);
    directed("jal_wrap", 2'd1, 32'hFFFF_FFFC, 32'h0, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000, 1'b0);
    directed("seq", 2'd3, 32'h0000_1002, 32'h5, 32'h7, 32'h0000_1006, 32'h0000_1006, exp_mis_on);

    // Backpressure: A and B fill the buffer, C waits for space.
    drain();
    @(posedge clock); #1;
    out_ready = 1'b0;
    set_in(2'd0, 32'h0000_0100, 32'h0, 32'h0000_0010);
    in_valid = 1'b1;
    @(negedge clock); check("bp_ready_a", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    set_in(2'd2, 32'h0000_0200, 32'h0000_0201, 32'h0000_0010);
    @(negedge clock); check("bp_ready_b", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    set_in(2'd1, 32'h0000_0300, 32'h0, 32'h0000_0020);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_ready_c_blocked", 32'(in_ready), 32'd0);
      check("bp_head_stable", out_target, 32'h0000_0110);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock); check("bp_ready_still_low_on_pop", 32'(in_ready), 32'd0);
    @(negedge clock); check("bp_ready_rises", 32'(in_ready), 32'd1);
    check("bp_head_b", out_target, 32'h0000_0210);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("bp_head_c_valid", 32'(out_valid), 32'd1);
    check("bp_head_c", out_target, 32'h0000_0320);
    drain();

    // Reset while two entries are buffered drops both.
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(2'd1, 32'h0000_4000, 32'h0, 32'h0000_0100);
    send(2'd0, 32'h0000_5000, 32'h0, 32'h0000_0200);
    check("full_before_reset", 32'(in_ready), 32'd0);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clock); #3;
    reset = 1'b0;
    out_ready = 1'b1;
    send(2'd1, 32'h0000_6000, 32'h0, 32'h0000_0040);
    check("post_reset_first", out_target, 32'h0000_6040);
    drain();

    // Randomized traffic with random backpressure and one async reset.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      set_in(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 700) begin
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rand_reset_valid", 32'(out_valid), 32'd0);
        @(posedge clock); #3;
        reset = 1'b0;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
